// File: rtl/led_btn_ctrl.sv
// Front-panel controller: synchronises and debounces buttons/switches and
// drives per-channel LEDs whose mode (OFF/ON/BLINK/PWM) is stepped by button presses.
module led_btn_ctrl #(
    parameter int N_CH       = 4,
    parameter int DEB_CYCLES = 50000,
    parameter int DIV_BITS   = 24,
    parameter int PWM_DUTY   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    input  logic [1:0]      sw,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] btn_db,
    output logic [N_CH-1:0] btn_rise,
    output logic [1:0]      sw_db
);

    localparam int NIN = N_CH + 2;
    localparam int CW  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    logic [NIN-1:0]      sync1;
    logic [NIN-1:0]      sync2;
    logic [NIN-1:0]      db;
    logic [NIN-1:0]      db_next;
    logic [CW-1:0]       deb_cnt      [NIN];
    logic [CW-1:0]       deb_cnt_next [NIN];
    logic [DIV_BITS-1:0] cnt;
    mode_t               mode      [N_CH];
    mode_t               mode_next [N_CH];
    logic [N_CH-1:0]     pattern;
    logic                pwm_on;

    // Switches ride on the top two bits so one debouncer array serves all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sw, btn};
            sync2 <= sync1;
        end
    end

    always_comb begin
        db_next = db;
        for (int i = 0; i < NIN; i++) begin
            deb_cnt_next[i] = '0;
            if (sync2[i] != db[i]) begin
                if (deb_cnt[i] == DEB_MAX) begin
                    db_next[i] = sync2[i];
                end else begin
                    deb_cnt_next[i] = deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db       <= '0;
            btn_rise <= '0;
            for (int i = 0; i < NIN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            db       <= db_next;
            btn_rise <= db_next[N_CH-1:0] & ~db[N_CH-1:0];
            for (int i = 0; i < NIN; i++) begin
                deb_cnt[i] <= deb_cnt_next[i];
            end
        end
    end

    assign btn_db = db[N_CH-1:0];
    assign sw_db  = db[NIN-1:N_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                mode[i] <= MODE_OFF;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                mode[i] <= mode_next[i];
            end
        end
    end

    // The lock level seen in the same cycle as the rise decides whether it counts.
    always_comb begin
        pattern = '0;
        pwm_on  = ({1'b0, cnt[3:0]} < 5'(PWM_DUTY));
        for (int i = 0; i < N_CH; i++) begin
            mode_next[i] = mode[i];
            if (btn_rise[i] && !sw_db[1]) begin
                mode_next[i] = mode_t'(mode[i] + 2'd1);
            end
            case (mode[i])
                MODE_OFF:   pattern[i] = 1'b0;
                MODE_ON:    pattern[i] = 1'b1;
                MODE_BLINK: pattern[i] = cnt[DIV_BITS-1];
                MODE_PWM:   pattern[i] = pwm_on;
                default:    pattern[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= pattern ^ {N_CH{sw_db[0]}};
        end
    end

endmodule

// File: tb/tb_led_btn_ctrl.sv
// Self-checking bench for led_btn_ctrl: directed scenarios plus random
// button/switch activity, all checked every cycle against a behavioural model.
module tb_led_btn_ctrl;

    localparam int N_CH = 4;
    localparam int DEB  = 4;
    localparam int DIV  = 4;
    localparam int PWM  = 4;
    localparam int PERIOD = 1 << DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'h0;
    logic [1:0] sw  = 2'b00;
    logic [3:0] led;
    logic [3:0] btn_db;
    logic [3:0] btn_rise;
    logic [1:0] sw_db;

    int n_compared   = 0;
    int n_mismatched = 0;

    led_btn_ctrl #(
        .N_CH(N_CH),
        .DEB_CYCLES(DEB),
        .DIV_BITS(DIV),
        .PWM_DUTY(PWM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .sw(sw),
        .led(led),
        .btn_db(btn_db),
        .btn_rise(btn_rise),
        .sw_db(sw_db)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pin history delayed two samples, debounce as a run
    // length of disagreeing samples, modes as integers counted modulo 4.
    bit [5:0] m_s1, m_s2, m_db, old_db;
    int       m_run [6];
    bit [3:0] m_rise, m_led, pat;
    int       m_mode [4];
    int       m_cnt;
    bit       m_ok = 1'b0;

    function automatic bit patternOf(input int md, input int c);
        case (md)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((c / (PERIOD / 2)) % 2) == 1;
            default: return (c % 16) < PWM;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_led = '0; m_cnt = 0;
            for (int j = 0; j < 6; j++) m_run[j] = 0;
            for (int i = 0; i < 4; i++) m_mode[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) pat[i] = patternOf(m_mode[i], m_cnt);
            m_led = pat ^ {4{m_db[4]}};
            for (int i = 0; i < 4; i++)
                if (m_rise[i] && !m_db[5]) m_mode[i] = (m_mode[i] + 1) % 4;
            m_cnt = (m_cnt + 1) % PERIOD;
            old_db = m_db;
            for (int j = 0; j < 6; j++) begin
                if (m_s2[j] != m_db[j]) begin
                    m_run[j]++;
                    if (m_run[j] == DEB) begin
                        m_db[j]  = m_s2[j];
                        m_run[j] = 0;
                    end
                end else begin
                    m_run[j] = 0;
                end
            end
            m_rise = m_db[3:0] & ~old_db[3:0];
            m_s2 = m_s1;
            m_s1 = {sw, btn};
        end
        m_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            checkOutput("model_led", 32'(led), 32'(m_led));
            checkOutput("model_btn_db", 32'(btn_db), 32'(m_db[3:0]));
            checkOutput("model_btn_rise", 32'(btn_rise), 32'(m_rise));
            checkOutput("model_sw_db", 32'(sw_db), 32'(m_db[5:4]));
        end
    end

    task automatic applyStimulus(input logic [3:0] b, input logic [1:0] s, input int cycles);
        btn = b;
        sw  = s;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        btn = 4'h0;
        sw  = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic waitDb(input int idx, input logic val, output int n);
        logic [5:0] v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            v = {sw_db, btn_db};
        end while (v[idx] !== val && n < 40);
    endtask

    task automatic press(input int ch, output logic saw);
        saw = 1'b0;
        btn[ch] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            saw = saw | btn_rise[ch];
        end
        btn[ch] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic countHigh(input int ch, output int k);
        k = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            if (led[ch]) k++;
        end
    endtask

    initial begin
        int   n;
        int   k;
        logic saw;

        $display("[TB] start");
        rst = 1'b1;
        btn = 4'hF;
        sw  = 2'b11;
        @(negedge clk);
        repeat (3) begin
            checkOutput("reset_led", 32'(led), 32'h0);
            checkOutput("reset_btn_db", 32'(btn_db), 32'h0);
            checkOutput("reset_btn_rise", 32'(btn_rise), 32'h0);
            checkOutput("reset_sw_db", 32'(sw_db), 32'h0);
            @(negedge clk);
        end
        rst = 1'b0;
        waitDb(0, 1'b1, n);
        checkOutput("reset_release_latency", 32'(n), 32'd6);

        doReset();
        btn = 4'h1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("glitch_btn_db0", 32'(btn_db[0]), 32'd0);
            checkOutput("glitch_btn_rise0", 32'(btn_rise[0]), 32'd0);
        end
        btn = 4'h0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("glitch_btn_db0", 32'(btn_db[0]), 32'd0);
            checkOutput("glitch_btn_rise0", 32'(btn_rise[0]), 32'd0);
        end
        btn = 4'h1;
        waitDb(0, 1'b1, n);
        checkOutput("debounce_latency", 32'(n), 32'd6);
        checkOutput("rise_first_cycle", 32'(btn_rise[0]), 32'd1);
        @(negedge clk);
        checkOutput("rise_one_cycle", 32'(btn_rise[0]), 32'd0);
        checkOutput("db_held", 32'(btn_db[0]), 32'd1);
        applyStimulus(4'h0, 2'b00, 10);

        doReset();
        press(1, saw);
        checkOutput("mode_on_led", 32'(led), 32'h2);
        press(1, saw);
        countHigh(1, k);
        checkOutput("blink_high_count", 32'(k), 32'd8);
        press(1, saw);
        countHigh(1, k);
        checkOutput("pwm_high_count", 32'(k), 32'd4);
        press(1, saw);
        checkOutput("mode_off_led", 32'(led), 32'h0);

        sw = 2'b01;
        waitDb(4, 1'b1, n);
        checkOutput("invert_sw_latency", 32'(n), 32'd6);
        @(negedge clk);
        checkOutput("invert_led", 32'(led), 32'hF);
        press(1, saw);
        press(1, saw);
        press(1, saw);
        countHigh(1, k);
        checkOutput("pwm_inverted_high", 32'(k), 32'd12);

        applyStimulus(4'h0, 2'b00, 10);
        sw = 2'b10;
        waitDb(5, 1'b1, n);
        checkOutput("lock_sw_latency", 32'(n), 32'd6);
        press(2, saw);
        checkOutput("lock_rise_seen", 32'(saw), 32'd1);
        checkOutput("lock_led_hold", 32'(led[2]), 32'd0);
        sw = 2'b00;
        waitDb(5, 1'b0, n);
        checkOutput("unlock_sw_latency", 32'(n), 32'd6);
        press(2, saw);
        checkOutput("unlock_led_on", 32'(led[2]), 32'd1);

        doReset();
        btn = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (led == 4'h0 && n < 40);
        checkOutput("simul_led", 32'(led), 32'hF);
        checkOutput("simul_latency", 32'(n), 32'd8);
        applyStimulus(4'h0, 2'b00, 10);
        applyStimulus(4'h8, 2'b00, 3);
        rst = 1'b1;
        btn = 4'h0;
        repeat (2) @(negedge clk);
        checkOutput("midreset_led", 32'(led), 32'h0);
        rst = 1'b0;
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (btn_rise != 4'h0) k++;
        end
        checkOutput("no_late_rise", 32'(k), 32'd0);
        checkOutput("post_reset_led", 32'(led), 32'h0);

        repeat (300) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
            applyStimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                          int'($urandom_range(1, 8)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/led_btn_ctrl.md
Name: led_btn_ctrl

Overview:
Parametrised front-panel controller for the Zynq fabric, clocked from the PS7 fabric clock.
- Synchronises and debounces N_CH push-buttons and two slide switches.
- Runs a free-running prescaler.
- Drives N_CH LEDs, each with its own mode (OFF/ON/BLINK/PWM). Button i cycles the mode of LED i.
- Switches provide a global output invert and a mode-lock.

Parameters:
N_CH, 4, number of button/LED channel pairs (1..16).
DEB_CYCLES, 50000, consecutive cycles a synchronised input must differ from its debounced value before the debounced value updates (>=2).
DIV_BITS, 24, prescaler width; BLINK period is 2^DIV_BITS cycles (>=4).
PWM_DUTY, 4, PWM on-count out of 16 (0..16).

Ports:
clk  in  1  fabric clock (PS7 FCLKCLK[0])
rst  in  1  synchronous reset, active-high
btn  in  N_CH  raw push-buttons, asynchronous, active-high
sw  in  2  raw slide switches, asynchronous; sw[0]=invert, sw[1]=lock
led  out  N_CH  LED drive, registered
btn_db  out  N_CH  debounced button levels
btn_rise  out  N_CH  one-cycle pulse on each debounced rising edge
sw_db  out  2  debounced switch levels

Behaviour:
- Reset (rst high at a clk edge) clears the following on that edge: sync flops, debounce counters, btn_db, btn_rise, sw_db, prescaler, all modes (OFF) and led. rst overrides all other activity, including mid-debounce.
- Synchroniser: 2-flop chain on every btn and sw bit. The synchronised value lags the pin by 2 cycles.
- Debouncer (one per input, N_CH+2 total):
  - Counter width is clog2(DEB_CYCLES).
  - If sync == debounced: counter clears to 0.
  - Otherwise the counter increments. When the counter == DEB_CYCLES-1, debounced takes the sync value and the counter clears on that same edge.
  - A glitch shorter than DEB_CYCLES cycles produces no change.
  - Total latency from a stable pin change to a btn_db/sw_db change is 2+DEB_CYCLES cycles.
- btn_rise[i]: registered. High for exactly one cycle, coincident with the first cycle btn_db[i]=1. No pulse on falling edges.
- Prescaler cnt[DIV_BITS-1:0]: increments every cycle and wraps from all-ones to 0.
- Mode register per channel (2 bits): 0=OFF, 1=ON, 2=BLINK, 3=PWM.
  - On btn_rise[i] with sw_db[1]=0, mode[i] advances OFF->ON->BLINK->PWM->OFF on the next edge.
  - With sw_db[1]=1, btn_rise is ignored and the mode holds. This applies even when the rise and the lock change occur in the same cycle: the lock value sampled in that cycle decides.
  - Channels are independent; simultaneous rises on several channels all take effect.
- LED pattern (combinational from the current mode and cnt):
  - OFF = 0
  - ON = 1
  - BLINK = cnt[DIV_BITS-1]
  - PWM = (cnt[3:0] < PWM_DUTY). PWM_DUTY=0 gives always 0; PWM_DUTY=16 gives always 1.
- led[i] <= pattern[i] XOR sw_db[0], registered, so led lags mode/cnt by 1 cycle. Invert applies to all modes, including OFF.
- Mode-change latency: btn_rise at cycle t -> mode updated at t+1 -> led reflects the new mode at t+2.

Test Plan:
(Bench parameters: N_CH=4, DEB_CYCLES=4, DIV_BITS=4, PWM_DUTY=4.)
1. Reset: hold rst 3 cycles with btn=4'hF, sw=2'b11 -> led=0, btn_db=0, btn_rise=0, sw_db=0 throughout; the first btn_db change occurs 6 cycles after rst deasserts.
2. Debounce: pulse btn[0] high for 3 cycles, then low -> btn_db[0] stays 0, no btn_rise. Then hold it high -> btn_db[0]=1 and btn_rise[0]=1 for one cycle, exactly 6 cycles after the rising pin edge.
3. Mode cycling: 4 clean presses on btn[1] -> led[1] goes 0 -> 1 -> 1/0 toggling every 8 cycles (BLINK) -> high 4 of every 16 cycles (PWM) -> 0. led[0], led[2] and led[3] stay 0.
4. Invert: set sw[0]=1 with all modes OFF -> after 6 cycles sw_db[0]=1; one cycle later led=4'hF. PWM channel then reads high 12 of every 16 cycles.
5. Lock: set sw[1]=1, wait until sw_db[1]=1, press btn[2] -> btn_rise[2] pulses, mode and led[2] unchanged. Release lock and press again -> led[2]=1.
6. Simultaneous/reset: press btn[0..3] together -> all four LEDs turn on in the same cycle. Then assert rst mid-debounce of btn[3] -> led=0, and there is no late btn_rise after reset.
